// File: rtl/key_event_decoder.sv
// key_event_decoder: turns debounced key_flag/key_state events into click, double-click,
// long-press and auto-repeat pulses, plus a hold level and a press counter.
module key_event_decoder #(
  parameter logic [31:0] LONG_CNT    = 32'd50_000_000,
  parameter logic [31:0] DBL_GAP_CNT = 32'd12_500_000,
  parameter logic [31:0] REPEAT_CNT  = 32'd5_000_000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       key_flag,
  input  logic       key_state,
  output logic       single_click,
  output logic       double_click,
  output logic       long_press,
  output logic       repeat_tick,
  output logic       hold_active,
  output logic [7:0] press_cnt
);
  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG} state_t;
  state_t state, next;
  logic [31:0] cnt;
  logic press_ev, rel_ev, sc_n, dc_n, lp_n, rt_n, run, clr, accept;
  assign press_ev = key_flag & ~key_state;
  assign rel_ev   = key_flag & key_state;
  assign run      = state inside {PRESS1, WAIT2, LONG};
  assign accept   = press_ev & (state == IDLE || state == WAIT2);
  // a repeat period expiring restarts the count without leaving LONG
  assign clr      = (next != state) | rt_n;
  always_comb begin
    next = state;
    sc_n = 1'b0;
    dc_n = 1'b0;
    lp_n = 1'b0;
    rt_n = 1'b0;
    case (state)
      IDLE:   next = press_ev ? PRESS1 : IDLE;
      PRESS1: begin
        lp_n = ~rel_ev & (cnt == LONG_CNT - 32'd1);
        next = rel_ev ? WAIT2 : lp_n ? LONG : PRESS1;
      end
      WAIT2:  begin
        sc_n = ~press_ev & (cnt == DBL_GAP_CNT - 32'd1);
        next = press_ev ? PRESS2 : sc_n ? IDLE : WAIT2;
      end
      PRESS2: begin
        dc_n = rel_ev;
        next = rel_ev ? IDLE : PRESS2;
      end
      LONG:   begin
        rt_n = ~rel_ev & (cnt == REPEAT_CNT - 32'd1);
        next = rel_ev ? IDLE : LONG;
      end
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      cnt          <= '0;
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      repeat_tick  <= 1'b0;
      hold_active  <= 1'b0;
      press_cnt    <= '0;
    end else begin
      state        <= next;
      cnt          <= clr ? '0 : run ? cnt + 32'd1 : cnt;
      single_click <= sc_n;
      double_click <= dc_n;
      long_press   <= lp_n;
      repeat_tick  <= rt_n;
      hold_active  <= next == LONG;
      press_cnt    <= press_cnt + {7'd0, accept};
    end
  end
endmodule

// File: tb/tb_key_event_decoder.sv
// tb_key_event_decoder: gesture table, hand-written corner sequences and random stimulus,
// all cross-checked cycle by cycle against a timestamp-based gesture model.
module tb_key_event_decoder;
  localparam int L = 100, D = 40, R = 20;
  logic Clk = 1'b0, Reset = 1'b1, key_flag = 1'b0, key_state = 1'b1;
  logic single_click, double_click, long_press, repeat_tick, hold_active;
  logic [7:0] press_cnt;
  key_event_decoder #(.LONG_CNT(L), .DBL_GAP_CNT(D), .REPEAT_CNT(R)) dut (
    .Clk(Clk), .Reset(Reset), .key_flag(key_flag), .key_state(key_state),
    .single_click(single_click), .double_click(double_click), .long_press(long_press),
    .repeat_tick(repeat_tick), .hold_active(hold_active), .press_cnt(press_cnt)
  );
  always #10 Clk = ~Clk;
  int n_cmp = 0, n_bad = 0, ecnt = 0;
  logic s_flag = 1'b0, s_state = 1'b1, s_reset = 1'b1;
  always @(posedge Clk) begin
    s_flag  <= key_flag;
    s_state <= key_state;
    s_reset <= Reset;
    ecnt    <= ecnt + 1;
  end
  // model: key-down flag, number of finished clicks, long-hold flag and event timestamps
  bit m_down, m_long;
  int m_clicks, m_t0, m_tl;
  logic [7:0] m_pcnt;
  logic e_sc, e_dc, e_lp, e_rt;
  int n_sc, n_dc, n_lp, n_rt, t_sc, t_lp, t_rt;
  task automatic model_step();
    bit pe, re;
    pe = s_flag & ~s_state;
    re = s_flag & s_state;
    {e_sc, e_dc, e_lp, e_rt} = '0;
    if (s_reset) begin
      m_down = 0; m_long = 0; m_clicks = 0; m_pcnt = 0;
    end else if (!m_down && m_clicks == 0) begin
      if (pe) begin m_down = 1; m_t0 = ecnt; m_pcnt++; end
    end else if (m_down && m_long) begin
      if (re) begin m_down = 0; m_long = 0; end
      else if ((ecnt - m_tl) % R == 0) e_rt = 1;
    end else if (m_down && m_clicks == 0) begin
      if (re) begin m_down = 0; m_clicks = 1; m_t0 = ecnt; end
      else if (ecnt - m_t0 == L) begin m_long = 1; m_tl = ecnt; e_lp = 1; end
    end else if (!m_down) begin
      if (pe) begin m_down = 1; m_pcnt++; end
      else if (ecnt - m_t0 == D) begin m_clicks = 0; e_sc = 1; end
    end else if (re) begin
      m_down = 0; m_clicks = 0; e_dc = 1;
    end
  endtask
  initial forever begin
    logic [12:0] act, exp;
    @(negedge Clk);
    model_step();
    act = {single_click, double_click, long_press, repeat_tick, hold_active, press_cnt};
    exp = {e_sc, e_dc, e_lp, e_rt, m_long, m_pcnt};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad < 30) $display("FAIL cycle %0d outputs: got %b expected %b", ecnt, act, exp);
    end
    if (single_click) begin if (t_sc < 0) t_sc = ecnt; n_sc++; end
    if (double_click) n_dc++;
    if (long_press) begin if (t_lp < 0) t_lp = ecnt; n_lp++; end
    if (repeat_tick) begin if (t_rt < 0) t_rt = ecnt; n_rt++; end
  end
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick(); @(posedge Clk); #1; endtask
  task automatic idle(int n); repeat (n) tick(); endtask
  task automatic ev(bit st); key_flag = 1'b1; key_state = st; tick(); key_flag = 1'b0; endtask
  task automatic clr();
    n_sc = 0; n_dc = 0; n_lp = 0; n_rt = 0; t_sc = -1; t_lp = -1; t_rt = -1;
  endtask
  task automatic rst(); Reset = 1'b1; tick(); Reset = 1'b0; endtask
  typedef struct { int p1; int gap; int p2; int sc; int dc; int lp; int rt; int dp; } vec_t;
  vec_t tbl[8];
  initial begin
    int t_press, t_rel;
    logic [7:0] p0;
    clr();
    idle(2);
    Reset = 1'b0;
    check("reset_outs", {single_click, double_click, long_press, repeat_tick, hold_active, press_cnt}, 0);
    tbl[0] = '{10, -1, 0, 1, 0, 0, 0, 1};
    tbl[1] = '{10, 15, 5, 0, 1, 0, 0, 2};
    tbl[2] = '{165, -1, 0, 0, 0, 1, 3, 1};
    tbl[3] = '{100, -1, 0, 1, 0, 0, 0, 1};
    tbl[4] = '{101, -1, 0, 0, 0, 1, 0, 1};
    tbl[5] = '{10, 40, 5, 0, 1, 0, 0, 2};
    tbl[6] = '{10, 41, 5, 2, 0, 0, 0, 2};
    tbl[7] = '{200, -1, 0, 0, 0, 1, 4, 1};
    foreach (tbl[i]) begin
      p0 = press_cnt;
      clr();
      ev(1'b0); t_press = ecnt; idle(tbl[i].p1 - 1);
      ev(1'b1); t_rel = ecnt;
      if (tbl[i].gap >= 0) begin
        idle(tbl[i].gap - 1); ev(1'b0); idle(tbl[i].p2 - 1); ev(1'b1);
      end
      idle(60);
      check($sformatf("tbl%0d_counts", i), {n_sc[7:0], n_dc[7:0], n_lp[7:0], n_rt[7:0]},
            {tbl[i].sc[7:0], tbl[i].dc[7:0], tbl[i].lp[7:0], tbl[i].rt[7:0]});
      check($sformatf("tbl%0d_press_cnt", i), press_cnt - p0, tbl[i].dp);
      if (tbl[i].sc > 0) check($sformatf("tbl%0d_sc_delay", i), t_sc - t_rel, D);
      if (tbl[i].lp > 0) check($sformatf("tbl%0d_lp_delay", i), t_lp - t_press, L);
      if (tbl[i].rt > 0) check($sformatf("tbl%0d_rt_delay", i), t_rt - t_lp, R);
    end
    // spurious events: release in idle, press during long-hold
    p0 = press_cnt;
    clr();
    ev(1'b1); idle(5);
    check("spur_rel_pcnt", press_cnt, p0);
    ev(1'b0); idle(110);
    ev(1'b0); idle(3);
    check("spur_press_pcnt", press_cnt, p0 + 8'd1);
    check("spur_press_hold", hold_active, 1);
    ev(1'b1); tick();
    check("spur_hold_off", hold_active, 0);
    check("spur_no_clicks", n_sc + n_dc, 0);
    // press counter wrap
    rst();
    clr();
    for (int i = 0; i < 256; i++) begin ev(1'b0); idle(2); ev(1'b1); idle(D + 3); end
    check("wrap_pcnt", press_cnt, 0);
    check("wrap_clicks", n_sc, 256);
    // reset in PRESS1, WAIT2 and LONG
    for (int k = 0; k < 3; k++) begin
      ev(1'b0);
      if (k == 0) idle(5);
      if (k == 1) begin idle(5); ev(1'b1); idle(10); end
      if (k == 2) idle(L + R + 5);
      clr();
      rst();
      check($sformatf("rst%0d_outs", k),
            {single_click, double_click, long_press, repeat_tick, hold_active, press_cnt}, 0);
      idle(L + 20);
      check($sformatf("rst%0d_no_pulse", k), n_sc + n_dc + n_lp + n_rt, 0);
      ev(1'b0); idle(3); ev(1'b1); t_rel = ecnt; idle(D + 5);
      check($sformatf("rst%0d_fresh_sc", k), t_sc - t_rel, D);
      check($sformatf("rst%0d_fresh_pcnt", k), press_cnt, 1);
    end
    // random traffic with occasional resets
    for (int b = 0; b < 30; b++) begin
      int rate;
      rate = (b % 3 == 0) ? 8 : (b % 3 == 1) ? 30 : 90;
      for (int k = 0; k < 500; k++) begin
        Reset = ($urandom_range(0, 2999) == 0);
        key_flag = ($urandom_range(0, rate - 1) == 0);
        key_state = 1'($urandom_range(0, 1));
        tick();
      end
    end
    Reset = 1'b0; key_flag = 1'b0;
    idle(200);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
